// File: rtl/audio_mix_resampler_pkg.sv
// Shared definitions for the audio back end: default widths, the mixer
// sequencing states and the shift-and-saturate helper.
package audio_pkg;

    localparam int DEF_IW  = 16;
    localparam int DEF_OW  = 16;
    localparam int DEF_NCH = 4;
    localparam int DEF_GW  = 8;
    localparam int DEF_PHW = 24;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        SAT,
        OUT
    } mix_state_t;

    // Arithmetic right shift followed by clamping to a signed ow-bit range.
    // Accumulators up to 64 bits wide are supported.
    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] sum,
        input int                 shift,
        input int                 ow
    );
        logic signed [63:0] shifted;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        logic signed [63:0] result;
        shifted = sum >>> shift;
        max_v   = (64'sd1 <<< (ow - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (ow - 1));
        if (shifted > max_v) begin
            result = max_v;
        end else if (shifted < min_v) begin
            result = min_v;
        end else begin
            result = shifted;
        end
        return result;
    endfunction

endpackage

// File: rtl/audio_mix_resampler_if.sv
// Source-side and output-side signals of the mixer/resampler, bundled so
// the producer (master) and the mixer (slave) see one connection.
interface audio_mix_resampler_if
    import audio_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int IW  = DEF_IW,
    parameter int OW  = DEF_OW,
    parameter int GW  = DEF_GW,
    parameter int PHW = DEF_PHW
) ();

    logic [NCH-1:0][IW-1:0] ch_in;
    logic [NCH-1:0]         ch_cen;
    logic [NCH-1:0][GW-1:0] ch_gain;
    logic [NCH-1:0][1:0]    ch_pan;
    logic [PHW-1:0]         phase_inc;
    logic                   mute;
    logic [OW-1:0]          snd_l_out;
    logic [OW-1:0]          snd_r_out;
    logic                   snd_valid;
    logic                   overrun;

    modport master (
        output ch_in, ch_cen, ch_gain, ch_pan, phase_inc, mute,
        input  snd_l_out, snd_r_out, snd_valid, overrun
    );

    modport slave (
        input  ch_in, ch_cen, ch_gain, ch_pan, phase_inc, mute,
        output snd_l_out, snd_r_out, snd_valid, overrun
    );

endinterface

// File: rtl/audio_mix_resampler_nco.sv
// Phase-accumulator NCO: the carry out of the accumulator is registered
// and presented as a one-cycle tick. Reusable by other audio blocks.
module audio_nco
    import audio_pkg::*;
#(
    parameter int PHW = DEF_PHW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [PHW-1:0] phase_inc,
    output logic           tick
);

    logic [PHW-1:0] acc;
    logic [PHW:0]   next_acc;

    assign next_acc = {1'b0, acc} + {1'b0, phase_inc};

    // Advance the phase every clock and register the wrap as the tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc  <= '0;
            tick <= 1'b0;
        end else begin
            acc  <= next_acc[PHW-1:0];
            tick <= next_acc[PHW];
        end
    end

endmodule

// File: rtl/audio_mix_resampler.sv
// Multi-source mixer and rate converter: zero-order holds per source, an
// NCO-driven sequence that visits one source per cycle applying gain and
// panning, then a shift/saturate stage producing one stereo pair per tick.
module audio_mix_resampler
    import audio_pkg::*;
#(
    parameter int IW  = DEF_IW,
    parameter int OW  = DEF_OW,
    parameter int NCH = DEF_NCH,
    parameter int GW  = DEF_GW,
    parameter int PHW = DEF_PHW
) (
    input  logic                 clk,
    input  logic                 reset,
    audio_mix_resampler_if.slave bus
);

    localparam int PW   = IW + GW + 1;
    localparam int AW   = PW + $clog2(NCH);
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0][IW-1:0] hold;
    logic                   tick;
    mix_state_t             state;
    logic [IDXW-1:0]        idx;
    logic signed [AW-1:0]   sum_l;
    logic signed [AW-1:0]   sum_r;
    logic signed [PW-1:0]   product;
    logic signed [AW-1:0]   product_ext;
    logic [1:0]             pan_sel;
    logic [OW-1:0]          sat_l;
    logic [OW-1:0]          sat_r;

    audio_nco #(
        .PHW(PHW)
    ) u_nco (
        .clk       (clk),
        .reset     (reset),
        .phase_inc (bus.phase_inc),
        .tick      (tick)
    );

    // Zero-order hold: each source keeps its last strobed sample. A visit on
    // the same cycle as a strobe reads the value from before the update.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.ch_cen[i]) begin
                    hold[i] <= bus.ch_in[i];
                end
            end
        end
    end

    // Gain product for the source being visited and the saturated results
    // of the current sums; gain is unsigned so it is widened with a zero.
    always_comb begin
        product     = PW'($signed(hold[idx])) * PW'($signed({1'b0, bus.ch_gain[idx]}));
        product_ext = AW'(product);
        pan_sel     = bus.ch_pan[idx];
        sat_l       = OW'(sat_shift(64'(sum_l), GW - 1, OW));
        sat_r       = OW'(sat_shift(64'(sum_r), GW - 1, OW));
    end

    // Mixing sequence. The saturated pair is registered on the edge that
    // leaves SAT, so snd_valid and the new outputs are visible during OUT;
    // ticks that land outside IDLE are dropped and latch overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            sum_l         <= '0;
            sum_r         <= '0;
            bus.snd_l_out <= '0;
            bus.snd_r_out <= '0;
            bus.snd_valid <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.snd_valid <= 1'b0;
            if (tick && (state != IDLE)) begin
                bus.overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (tick) begin
                        state <= ACC;
                        idx   <= '0;
                        sum_l <= '0;
                        sum_r <= '0;
                    end
                end
                ACC: begin
                    if (pan_sel[1]) begin
                        sum_l <= sum_l + product_ext;
                    end
                    if (pan_sel[0]) begin
                        sum_r <= sum_r + product_ext;
                    end
                    if (idx == IDXW'(NCH - 1)) begin
                        state <= SAT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                SAT: begin
                    bus.snd_l_out <= bus.mute ? '0 : sat_l;
                    bus.snd_r_out <= bus.mute ? '0 : sat_r;
                    bus.snd_valid <= 1'b1;
                    state         <= OUT;
                end
                OUT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_mix_resampler.sv
// Bench for audio_mix_resampler: scenario tasks drive sources and the NCO,
// push expected stereo pairs into a queue and compare them as pulses arrive.
module tb_audio_mix_resampler;
    import audio_pkg::*;

    localparam int NCH = 4;
    localparam int IW  = 16;
    localparam int OW  = 16;
    localparam int GW  = 8;
    localparam int PHW = 24;
    localparam logic [PHW-1:0] INC64 = 24'h040000;
    localparam logic [PHW-1:0] INC4  = 24'h400000;

    typedef struct packed {
        logic [OW-1:0] l;
        logic [OW-1:0] r;
    } pair_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int compared   = 0;
    int mismatched = 0;
    pair_t exp_q[$];
    logic [IW-1:0] tb_hold [NCH];
    logic [GW-1:0] tb_gain [NCH];
    logic [1:0]    tb_pan  [NCH];

    audio_mix_resampler_if #(.NCH(NCH), .IW(IW), .OW(OW), .GW(GW), .PHW(PHW)) bus ();

    audio_mix_resampler #(.IW(IW), .OW(OW), .NCH(NCH), .GW(GW), .PHW(PHW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference mix of the bench's own view of holds, gains and pans.
    function automatic pair_t model_mix(input logic mute_v);
        longint sl, sr, p;
        pair_t  res;
        sl = 0;
        sr = 0;
        for (int i = 0; i < NCH; i++) begin
            p = longint'($signed(tb_hold[i])) * longint'({1'b0, tb_gain[i]});
            if (tb_pan[i][1]) sl += p;
            if (tb_pan[i][0]) sr += p;
        end
        sl = sl >>> (GW - 1);
        sr = sr >>> (GW - 1);
        if (sl > 32767) sl = 32767; else if (sl < -32768) sl = -32768;
        if (sr > 32767) sr = 32767; else if (sr < -32768) sr = -32768;
        res.l = mute_v ? '0 : OW'(sl);
        res.r = mute_v ? '0 : OW'(sr);
        return res;
    endfunction

    task automatic drive_config();
        for (int i = 0; i < NCH; i++) begin
            bus.ch_gain[i] = tb_gain[i];
            bus.ch_pan[i]  = tb_pan[i];
        end
    endtask

    task automatic load_all();
        @(negedge clk);
        for (int i = 0; i < NCH; i++) bus.ch_in[i] = tb_hold[i];
        bus.ch_cen = '1;
        @(negedge clk);
        bus.ch_cen = '0;
    endtask

    // Leaves the bench at a negedge with reset just released: the next
    // posedge is the first one that advances the NCO.
    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        bus.ch_cen = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NCH; i++) tb_hold[i] = '0;
    endtask

    task automatic quiesce();
        bus.phase_inc = '0;
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, output logic got, output pair_t obs);
        got = 1'b0;
        obs = '0;
        for (int c = 0; c < budget && !got; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.snd_valid) begin
                got = 1'b1;
                obs = {bus.snd_l_out, bus.snd_r_out};
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if (bus.snd_l_out !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_l: got %h expected 0000", bus.snd_l_out); end
        compared++; if (bus.snd_r_out !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_r: got %h expected 0000", bus.snd_r_out); end
        compared++; if (bus.snd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.snd_valid); end
        compared++; if (bus.overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overrun: got %b expected 0", bus.overrun); end
    endtask

    task automatic test_rate();
        int    edges[$];
        int    b2b;
        logic  prev_valid;
        pair_t exp, obs;
        bus.phase_inc = INC64;
        do_reset();
        exp_q.delete();
        repeat (3) exp_q.push_back('0);
        prev_valid = 1'b0;
        b2b        = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.snd_valid) begin
                edges.push_back(k);
                if (prev_valid) b2b++;
                obs = {bus.snd_l_out, bus.snd_r_out};
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++; $display("[TB] FAIL rate_extra_pulse: pulse at edge %0d, none expected", k);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin mismatched++; $display("[TB] FAIL rate_value: got %h expected %h", obs, exp); end
                end
            end
            prev_valid = bus.snd_valid;
        end
        compared++;
        if (edges.size() != 3) begin
            mismatched++; $display("[TB] FAIL rate_count: got %0d pulses expected 3", edges.size());
        end else begin
            compared++; if (edges[0] != 70) begin mismatched++; $display("[TB] FAIL rate_first: pulse at edge %0d expected 70", edges[0]); end
            compared++; if (edges[1] - edges[0] != 64) begin mismatched++; $display("[TB] FAIL rate_period1: got %0d expected 64", edges[1] - edges[0]); end
            compared++; if (edges[2] - edges[1] != 64) begin mismatched++; $display("[TB] FAIL rate_period2: got %0d expected 64", edges[2] - edges[1]); end
        end
        compared++; if (b2b != 0) begin mismatched++; $display("[TB] FAIL rate_b2b: got %0d consecutive pulses expected 0", b2b); end
        compared++; if (bus.overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL rate_overrun: got %b expected 0", bus.overrun); end
    endtask

    task automatic test_single_source();
        logic  got;
        pair_t exp, obs;
        quiesce();
        tb_hold = '{16'h1000, 16'h1234, 16'h7000, 16'h8000};
        tb_gain = '{8'h80, 8'h00, 8'h00, 8'h00};
        tb_pan  = '{2'b10, 2'b11, 2'b11, 2'b11};
        drive_config();
        load_all();
        exp_q.delete();
        repeat (3) exp_q.push_back({16'h1000, 16'h0000});
        bus.phase_inc = INC64;
        for (int n = 0; n < 3; n++) begin
            wait_valid(150, got, obs);
            exp = exp_q.pop_front();
            compared++;
            if (!got) begin
                mismatched++; $display("[TB] FAIL single_timeout: pulse %0d missing, got none expected one", n);
            end else begin
                compared++; if (obs.l !== exp.l) begin mismatched++; $display("[TB] FAIL single_l: got %h expected %h", obs.l, exp.l); end
                compared++; if (obs.r !== exp.r) begin mismatched++; $display("[TB] FAIL single_r: got %h expected %h", obs.r, exp.r); end
            end
        end
    endtask

    task automatic test_full_scale();
        logic  got;
        pair_t exp, obs;
        for (int ph = 0; ph < 2; ph++) begin
            quiesce();
            for (int i = 0; i < NCH; i++) begin
                tb_hold[i] = (ph == 0) ? 16'h7FFF : 16'h8000;
                tb_gain[i] = 8'hFF;
                tb_pan[i]  = 2'b11;
            end
            drive_config();
            load_all();
            exp_q.delete();
            repeat (2) exp_q.push_back((ph == 0) ? {16'h7FFF, 16'h7FFF} : {16'h8000, 16'h8000});
            bus.phase_inc = INC64;
            for (int n = 0; n < 2; n++) begin
                wait_valid(150, got, obs);
                exp = exp_q.pop_front();
                compared++;
                if (!got) begin
                    mismatched++; $display("[TB] FAIL full_timeout: phase %0d pulse %0d missing", ph, n);
                end else begin
                    compared++; if (obs !== exp) begin mismatched++; $display("[TB] FAIL full_scale: phase %0d got %h expected %h", ph, obs, exp); end
                end
            end
        end
    endtask

    task automatic test_mix_model();
        logic  got;
        pair_t exp, obs;
        for (int rnd = 0; rnd < 4; rnd++) begin
            quiesce();
            for (int i = 0; i < NCH; i++) begin
                tb_hold[i] = IW'($urandom);
                tb_gain[i] = GW'($urandom);
                tb_pan[i]  = 2'($urandom);
            end
            tb_pan[0] = 2'b11;
            tb_gain[0] = 8'h80;
            drive_config();
            load_all();
            bus.mute = (rnd == 3);
            exp_q.delete();
            exp_q.push_back(model_mix(rnd == 3));
            bus.phase_inc = INC64;
            wait_valid(150, got, obs);
            exp = exp_q.pop_front();
            compared++;
            if (!got) begin
                mismatched++; $display("[TB] FAIL mix_timeout: round %0d no pulse", rnd);
            end else begin
                compared++; if (obs !== exp) begin mismatched++; $display("[TB] FAIL mix_round%0d: got %h expected %h", rnd, obs, exp); end
            end
        end
        bus.mute = 1'b0;
    endtask

    task automatic test_overrun();
        int   edges[$];
        int   b2b;
        logic prev_valid;
        bus.phase_inc = INC4;
        do_reset();
        prev_valid = 1'b0;
        b2b        = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 4) begin
                compared++; if (bus.overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL overrun_early: got %b expected 0", bus.overrun); end
            end
            if (bus.snd_valid) begin
                edges.push_back(k);
                if (prev_valid) b2b++;
            end
            prev_valid = bus.snd_valid;
        end
        compared++; if (bus.overrun !== 1'b1) begin mismatched++; $display("[TB] FAIL overrun_flag: got %b expected 1", bus.overrun); end
        compared++; if (edges.size() != 12) begin mismatched++; $display("[TB] FAIL overrun_count: got %0d pulses expected 12", edges.size()); end
        compared++; if (edges.size() == 0 || edges[0] != 10) begin mismatched++; $display("[TB] FAIL overrun_first: first pulse edge %0d expected 10", (edges.size() == 0) ? -1 : edges[0]); end
        compared++; if (b2b != 0) begin mismatched++; $display("[TB] FAIL overrun_b2b: got %0d consecutive pulses expected 0", b2b); end
    endtask

    task automatic test_cen_collision();
        pair_t exp, obs;
        tb_gain = '{8'h00, 8'h00, 8'h80, 8'h00};
        tb_pan  = '{2'b00, 2'b00, 2'b11, 2'b00};
        drive_config();
        bus.phase_inc = INC64;
        do_reset();
        compared++; if (bus.overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL collision_overrun_clear: got %b expected 0", bus.overrun); end
        exp_q.delete();
        exp_q.push_back({16'h0040, 16'h0040});
        exp_q.push_back({16'h0100, 16'h0100});
        for (int k = 1; k <= 140; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus.ch_cen = '0;
            if (k == 2)  begin bus.ch_in[2] = 16'h0040; bus.ch_cen[2] = 1'b1; end
            if (k == 67) begin bus.ch_in[2] = 16'h0100; bus.ch_cen[2] = 1'b1; end
            if (bus.snd_valid) begin
                obs = {bus.snd_l_out, bus.snd_r_out};
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++; $display("[TB] FAIL collision_extra: pulse at edge %0d, none expected", k);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin mismatched++; $display("[TB] FAIL collision_value: edge %0d got %h expected %h", k, obs, exp); end
                end
            end
        end
        bus.ch_cen = '0;
        compared++; if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL collision_missing: %0d pulses outstanding expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        pair_t exp, obs;
        tb_gain = '{8'h80, 8'h00, 8'h00, 8'h00};
        tb_pan  = '{2'b11, 2'b00, 2'b00, 2'b00};
        drive_config();
        bus.phase_inc = INC64;
        do_reset();
        exp_q.delete();
        exp_q.push_back({16'h1000, 16'h1000});
        for (int k = 1; k <= 134; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus.ch_cen = '0;
            if (k == 2) begin bus.ch_in[0] = 16'h1000; bus.ch_cen[0] = 1'b1; end
            if (k >= 132) begin
                compared++; if (bus.snd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_valid: edge %0d got 1 expected 0", k); end
            end else if (bus.snd_valid) begin
                obs = {bus.snd_l_out, bus.snd_r_out};
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++; $display("[TB] FAIL midreset_extra: pulse at edge %0d, none expected", k);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin mismatched++; $display("[TB] FAIL midreset_pre: got %h expected %h", obs, exp); end
                end
            end
            if (k == 131) reset = 1'b1;
        end
        compared++; if ({bus.snd_l_out, bus.snd_r_out} !== 32'h0) begin mismatched++; $display("[TB] FAIL midreset_outputs: got %h%h expected 00000000", bus.snd_l_out, bus.snd_r_out); end
        compared++; if (bus.overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_overrun: got %b expected 0", bus.overrun); end
        compared++; if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL midreset_missing: %0d pulses outstanding expected 0", exp_q.size()); end
        reset = 1'b0;
        exp_q.delete();
        exp_q.push_back({16'h0000, 16'h0000});
        exp_q.push_back({16'h2000, 16'h2000});
        for (int k = 1; k <= 140; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus.ch_cen = '0;
            if (k == 75) begin bus.ch_in[0] = 16'h2000; bus.ch_cen[0] = 1'b1; end
            if (bus.snd_valid) begin
                obs = {bus.snd_l_out, bus.snd_r_out};
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++; $display("[TB] FAIL resume_extra: pulse at edge %0d, none expected", k);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin mismatched++; $display("[TB] FAIL resume_value: edge %0d got %h expected %h", k, obs, exp); end
                end
            end
        end
        bus.ch_cen = '0;
        compared++; if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL resume_missing: %0d pulses outstanding expected 0", exp_q.size()); end
    endtask

    initial begin
        bus.ch_in     = '0;
        bus.ch_cen    = '0;
        bus.ch_gain   = '0;
        bus.ch_pan    = '0;
        bus.phase_inc = '0;
        bus.mute      = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            tb_hold[i] = '0;
            tb_gain[i] = '0;
            tb_pan[i]  = '0;
        end
        $display("[TB] starting audio_mix_resampler scenarios");
        test_reset();
        test_rate();
        test_single_source();
        test_full_scale();
        test_mix_model();
        test_overrun();
        test_cen_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/audio_mix_resampler.md
# audio_mix_resampler

Parametrised multi-source audio mixer and rate converter for the audio back end. It is the successor to the fixed three-source CIC resampling chain. The block accepts NCH mono sources, each arriving at its own sample rate on its own clock-enable. It applies per-channel gain and left/right routing, sums the sources with saturation, and emits stereo samples at an arbitrary output rate set by a phase-accumulator NCO. The source rates and the output rate are no longer hard-wired dividers.

## Interface
- IW, 16: input sample width, signed two's complement
- OW, 16: output sample width, signed
- NCH, 4: number of input sources, 1..16
- GW, 8: gain width, unsigned Q1.(GW-1); 2^(GW-1) is unity
- PHW, 24: NCO phase accumulator width

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ch_in  in  NCH×IW  per-source sample, signed
- ch_cen  in  NCH  per-source sample strobe, one-cycle pulse
- ch_gain  in  NCH×GW  per-source gain
- ch_pan  in  NCH×2  bit1 routes the source to left, bit0 routes it to right
- phase_inc  in  PHW  output rate = f_clk·phase_inc/2^PHW
- mute  in  1  forces the output sample to zero
- snd_l_out  out  OW  left output sample
- snd_r_out  out  OW  right output sample
- snd_valid  out  1  one-cycle pulse when a new output pair is available
- overrun  out  1  sticky flag; set when an output tick is dropped

## Operation
- Input hold: when ch_cen[i]=1, ch_in[i] is latched into hold[i]. This is a zero-order hold; each source is otherwise independent.
- NCO: acc <= acc + phase_inc on every clock. A carry out of bit PHW-1 is a tick. phase_inc=0 means no ticks.
- FSM states:
  - IDLE: on tick, go to ACC, clear sumL/sumR, set idx=0.
  - ACC: one source per cycle.
    - p = signed(hold[idx]) × signed({1'b0, ch_gain[idx]}), width IW+GW+1.
    - If ch_pan[idx][1], sumL += p; if ch_pan[idx][0], sumR += p.
    - Accumulator width is IW+GW+1+clog2(NCH).
    - After idx=NCH-1, go to SAT.
  - SAT: arithmetic shift of each sum right by GW-1, then saturate to [-2^(OW-1), 2^(OW-1)-1]. Go to OUT.
  - OUT: register the saturated values (zero if mute=1) into snd_*_out, pulse snd_valid, go to IDLE.
- hold, ch_gain and ch_pan are sampled on the cycle a source is visited. If ch_cen[i] coincides with the visit of source i, the pre-update hold[i] is used.
- A tick arriving while the FSM is not in IDLE is dropped, sets overrun, and does not disturb the sequence in progress. overrun clears only on reset.
- Guaranteed-safe rate: phase_inc ≤ 2^PHW/(NCH+3).

## Timing
- Reset values: acc=0, hold[*]=0, FSM=IDLE, snd_l_out=snd_r_out=0, snd_valid=0, overrun=0.
- Latency: snd_valid is high exactly NCH+2 clocks after the edge on which acc wraps. The outputs change only on that same cycle and hold between pulses.
- snd_valid is never high on two consecutive cycles.
- Reset asserted mid-sequence aborts the sequence: no snd_valid pulse, outputs return to 0.
- mute, phase_inc, ch_gain and ch_pan may change at any time; changes take effect on the next sample/visit.

## Structure
- Shared package audio_pkg holds:
  - the FSM state enum (IDLE, ACC, SAT, OUT);
  - function sat_shift(sum, shift, ow), used for the shift and saturation;
  - the default width constants.
- One sub-module, audio_nco (PHW-wide phase accumulator with registered tick output), which is reusable by other audio blocks. Mixer FSM, hold registers and datapath stay in the top module.

## Test plan
- NCH=4, ch0 hold=0x1000, gain=0x80, pan=2'b10, others gain=0 → every snd_valid gives L=0x1000, R=0x0000.
- All four sources 0x7FFF, gain=0xFF, pan=2'b11 → L=R=0x7FFF. All four -0x8000 → L=R=0x8000. No wrap in either case.
- phase_inc=2^PHW/64 → snd_valid every 64 clocks; the first pulse is NCH+2 clocks after the first wrap; overrun stays 0.
- phase_inc=2^PHW/4 with NCH=4 → overrun=1 after the second tick, pulses continue, and no pulse occurs in the cycle immediately after a pulse.
- ch_cen[2] pulsed with 0x0100 on the exact cycle source 2 is visited (gain 0x80, previous hold 0x0040) → output reflects 0x0040; the next output reflects 0x0100.
- reset asserted during the ACC state → no snd_valid, outputs 0, overrun 0, hold 0; normal operation resumes after deassertion.
